// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch stage: default widths,
// reset vector, timeout, and the fetch FSM state encoding.
package fetch_pkg;

    localparam int AW_DEF      = 16;
    localparam int DW_DEF      = 16;
    localparam int TIMEOUT_DEF = 15;
    localparam int CNT_W       = 8;
    localparam int PERF_W      = 16;

    localparam logic [15:0] RESET_VEC_DEF = 16'h0000;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_REQ   = 3'd1,
        ST_HOLD  = 3'd2,
        ST_DRAIN = 3'd3,
        ST_FAULT = 3'd4
    } fetch_state_e;

endpackage

// File: rtl/fetch_next_pc.sv
// Next-PC selection for the PC register D input: reset vector, hold,
// sequential increment (wraps modulo 2^AW) or branch redirect.
module fetch_next_pc
    import fetch_pkg::*;
#(
    parameter int            AW        = AW_DEF,
    parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF)
) (
    input  logic          rst,
    input  logic          fault,
    input  logic          br_valid,
    input  logic [AW-1:0] br_target,
    input  logic          advance,
    input  logic [AW-1:0] pc_q,
    output logic [AW-1:0] pc_d
);

    // Redirect beats advance beats hold; a faulted stage freezes the PC.
    always_comb begin
        pc_d = pc_q;
        if (rst) begin
            pc_d = RESET_VEC;
        end else if (fault) begin
            pc_d = pc_q;
        end else if (br_valid) begin
            pc_d = br_target;
        end else if (advance) begin
            pc_d = pc_q + AW'(1);
        end
    end

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: fetches over a req/ack memory port, holds the
// word in IR for the decoder and drives the PC register's D input.
// Optional feature macro: FETCH_PERF_EN adds saturating PERF_FETCHED and
// PERF_STALL counters.
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int            AW        = AW_DEF,
    parameter int            DW        = DW_DEF,
    parameter logic [AW-1:0] RESET_VEC = AW'(RESET_VEC_DEF),
    parameter int            TIMEOUT   = TIMEOUT_DEF
) (
    input  logic          CLK,
    input  logic          RST,
    input  logic [AW-1:0] PC_Q,
    output logic [AW-1:0] PC_D,
    output logic          MEM_REQ,
    output logic [AW-1:0] MEM_ADDR,
    input  logic          MEM_ACK,
    input  logic [DW-1:0] MEM_RDATA,
    output logic [DW-1:0] IR,
    output logic [AW-1:0] IR_PC,
    output logic          IR_VALID,
    input  logic          IR_READY,
    input  logic          BR_VALID,
    input  logic [AW-1:0] BR_TARGET,
    output logic          FAULT
`ifdef FETCH_PERF_EN
    ,
    output logic [PERF_W-1:0] PERF_FETCHED,
    output logic [PERF_W-1:0] PERF_STALL
`endif
);

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    fetch_state_e   state_q, state_d;
    logic [AW-1:0]  mem_addr_q, mem_addr_d;
    logic [DW-1:0]  ir_q, ir_d;
    logic [AW-1:0]  ir_pc_q, ir_pc_d;
    logic           ir_valid_q, ir_valid_d;
    logic           fault_q, fault_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic           advance;
    logic           in_fault;

    assign advance  = (state_q == ST_HOLD) && IR_READY;
    assign in_fault = (state_q == ST_FAULT);

    fetch_next_pc #(
        .AW        (AW),
        .RESET_VEC (RESET_VEC)
    ) u_next_pc (
        .rst       (RST),
        .fault     (in_fault),
        .br_valid  (BR_VALID),
        .br_target (BR_TARGET),
        .advance   (advance),
        .pc_q      (PC_Q),
        .pc_d      (PC_D)
    );

    // Fetch FSM: request sequencing, IR capture, redirect and timeout handling.
    always_comb begin
        state_d    = state_q;
        mem_addr_d = mem_addr_q;
        ir_d       = ir_q;
        ir_pc_d    = ir_pc_q;
        ir_valid_d = ir_valid_q;
        fault_d    = fault_q;
        wait_cnt_d = wait_cnt_q;
        case (state_q)
            ST_IDLE: begin
                // PC_D here is PC_Q unless a redirect arrives, keeping PC and address aligned.
                mem_addr_d = PC_D;
                state_d    = ST_REQ;
            end
            ST_REQ: begin
                if (MEM_ACK) begin
                    wait_cnt_d = '0;
                    if (BR_VALID) begin
                        mem_addr_d = BR_TARGET;
                    end else begin
                        ir_d       = MEM_RDATA;
                        ir_pc_d    = mem_addr_q;
                        ir_valid_d = 1'b1;
                        state_d    = ST_HOLD;
                    end
                end else if (wait_cnt_q == TO_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                    if (BR_VALID) begin
                        state_d = ST_DRAIN;
                    end
                end
            end
            ST_HOLD: begin
                if (BR_VALID) begin
                    ir_valid_d = 1'b0;
                    mem_addr_d = BR_TARGET;
                    state_d    = ST_REQ;
                end else if (IR_READY) begin
                    ir_valid_d = 1'b0;
                    mem_addr_d = PC_D;
                    state_d    = ST_REQ;
                end
            end
            ST_DRAIN: begin
                if (MEM_ACK) begin
                    // Stale data is dropped; refetch from where the PC now points,
                    // including a redirect that lands on the same cycle as the ack.
                    wait_cnt_d = '0;
                    mem_addr_d = PC_D;
                    state_d    = ST_REQ;
                end else if (wait_cnt_q == TO_LAST) begin
                    fault_d = 1'b1;
                    state_d = ST_FAULT;
                end else begin
                    wait_cnt_d = wait_cnt_q + CNT_W'(1);
                end
            end
            ST_FAULT: begin
                ir_valid_d = 1'b0;
            end
            default: begin
                state_d = ST_FAULT;
                fault_d = 1'b1;
            end
        endcase
    end

    // State and datapath registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_q    <= ST_IDLE;
            mem_addr_q <= RESET_VEC;
            ir_q       <= '0;
            ir_pc_q    <= '0;
            ir_valid_q <= 1'b0;
            fault_q    <= 1'b0;
            wait_cnt_q <= '0;
        end else begin
            state_q    <= state_d;
            mem_addr_q <= mem_addr_d;
            ir_q       <= ir_d;
            ir_pc_q    <= ir_pc_d;
            ir_valid_q <= ir_valid_d;
            fault_q    <= fault_d;
            wait_cnt_q <= wait_cnt_d;
        end
    end

    assign MEM_REQ  = (state_q == ST_REQ) || (state_q == ST_DRAIN);
    assign MEM_ADDR = mem_addr_q;
    assign IR       = ir_q;
    assign IR_PC    = ir_pc_q;
    assign IR_VALID = ir_valid_q;
    assign FAULT    = fault_q;

`ifdef FETCH_PERF_EN
    logic [PERF_W-1:0] fetched_q, fetched_d;
    logic [PERF_W-1:0] stall_q, stall_d;

    // Saturating counts of decoder handshakes and unacknowledged request cycles.
    always_comb begin
        fetched_d = fetched_q;
        stall_d   = stall_q;
        if (ir_valid_q && IR_READY && (fetched_q != '1)) begin
            fetched_d = fetched_q + PERF_W'(1);
        end
        if (MEM_REQ && !MEM_ACK && (stall_q != '1)) begin
            stall_d = stall_q + PERF_W'(1);
        end
    end

    // Performance counter registers.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            fetched_q <= '0;
            stall_q   <= '0;
        end else begin
            fetched_q <= fetched_d;
            stall_q   <= stall_d;
        end
    end

    assign PERF_FETCHED = fetched_q;
    assign PERF_STALL   = stall_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Scoreboard bench for fetch_unit: a PC register model, a memory responder
// with programmable ack latency, and a handshake monitor checking IR/IR_PC.
module tb_fetch_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic [15:0] PC_D;
    logic [15:0] pc_reg;
    logic        MEM_REQ;
    logic [15:0] MEM_ADDR;
    logic        MEM_ACK;
    logic [15:0] MEM_RDATA;
    logic [15:0] IR;
    logic [15:0] IR_PC;
    logic        IR_VALID;
    logic        IR_READY;
    logic        BR_VALID;
    logic [15:0] BR_TARGET;
    logic        FAULT;
`ifdef FETCH_PERF_EN
    logic [15:0] perf_fetched;
    logic [15:0] perf_stall;
`endif

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] data;
    } fetch_t;

    fetch_t      exp_q[$];
    logic [15:0] mem [logic [15:0]];
    int          n_vec     = 0;
    int          n_miss    = 0;
    int          hs_count  = 0;
    int          cyc       = 0;
    int          hs_cyc[64];
    int          ack_delay = 0;
    int          wait_cnt  = 0;

    fetch_unit dut (
        .CLK       (CLK),
        .RST       (RST),
        .PC_Q      (pc_reg),
        .PC_D      (PC_D),
        .MEM_REQ   (MEM_REQ),
        .MEM_ADDR  (MEM_ADDR),
        .MEM_ACK   (MEM_ACK),
        .MEM_RDATA (MEM_RDATA),
        .IR        (IR),
        .IR_PC     (IR_PC),
        .IR_VALID  (IR_VALID),
        .IR_READY  (IR_READY),
        .BR_VALID  (BR_VALID),
        .BR_TARGET (BR_TARGET),
        .FAULT     (FAULT)
`ifdef FETCH_PERF_EN
        ,
        .PERF_FETCHED (perf_fetched),
        .PERF_STALL   (perf_stall)
`endif
    );

    always #5 CLK = ~CLK;

    // The PC register this stage drives: loads D every edge, reset to 0000.
    always @(posedge CLK or posedge RST) begin
        if (RST) pc_reg <= 16'h0000;
        else     pc_reg <= PC_D;
    end

    always @(posedge CLK) cyc <= cyc + 1;

    function automatic logic [15:0] mem_read(input logic [15:0] a);
        if (mem.exists(a)) return mem[a];
        return ~a;
    endfunction

    task automatic check_output(input string name, input logic [15:0] act, input logic [15:0] req);
        n_vec++;
        if (act !== req) begin
            n_miss++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, req);
        end
    endtask

    task automatic tick;
        @(posedge CLK);
        #2;
    endtask

    task automatic wait_valid(input int budget);
        int n = 0;
        while (!IR_VALID && n < budget) begin
            tick;
            n++;
        end
    endtask

    // Memory responder: acks once a request has waited ack_delay cycles.
    initial begin
        MEM_ACK   = 1'b0;
        MEM_RDATA = 16'h0000;
        forever begin
            @(posedge CLK);
            #1;
            if (MEM_REQ) begin
                if (wait_cnt >= ack_delay) begin
                    MEM_ACK   = 1'b1;
                    MEM_RDATA = mem_read(MEM_ADDR);
                    wait_cnt  = 0;
                end else begin
                    MEM_ACK = 1'b0;
                    wait_cnt++;
                end
            end else begin
                MEM_ACK  = 1'b0;
                wait_cnt = 0;
            end
        end
    end

    // Monitor: every decoder handshake must match the next expected fetch.
    initial begin
        forever begin
            @(negedge CLK);
            if (!RST && IR_VALID && IR_READY) begin
                if (exp_q.size() == 0) begin
                    n_vec++;
                    n_miss++;
                    $display("[TB] FAIL unexpected_fetch: got IR=%h IR_PC=%h, expected none", IR, IR_PC);
                end else begin
                    fetch_t e;
                    e = exp_q.pop_front();
                    check_output("ir_data", IR, e.data);
                    check_output("ir_pc", IR_PC, e.addr);
                end
                if (hs_count < 64) hs_cyc[hs_count] = cyc;
                hs_count++;
            end
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: got no completion, expected finish");
        $fatal(1, "[TB] watchdog expired");
    end

    // Directed stimulus.
    initial begin
        int n;
        int hs_goal;
        mem[16'h0000] = 16'hABCD;
        mem[16'h0001] = 16'h107F;
        mem[16'h0002] = 16'h538D;
        mem[16'hFFFF] = 16'h7E57;
        mem[16'h1010] = 16'hC0DE;
        IR_READY  = 1'b1;
        BR_VALID  = 1'b0;
        BR_TARGET = 16'h0000;

        // Reset values.
        tick;
        tick;
        #1;
        check_output("rst_pc_d", PC_D, 16'h0000);
        check_output("rst_mem_req", 16'(MEM_REQ), 16'h0);
        check_output("rst_ir_valid", 16'(IR_VALID), 16'h0);
        check_output("rst_fault", 16'(FAULT), 16'h0);
        check_output("rst_mem_addr", MEM_ADDR, 16'h0000);

        // Release: one IDLE cycle, then request address 0000.
        tick;
        RST = 1'b0;
        #1;
        check_output("idle_mem_req", 16'(MEM_REQ), 16'h0);
        n = 0;
        while (!MEM_REQ && n < 2) begin
            tick;
            n++;
        end
        check_output("start_mem_req", 16'(MEM_REQ), 16'h1);
        check_output("start_mem_addr", MEM_ADDR, 16'h0000);

        // Straight-line fetch with same-cycle ack.
        exp_q.push_back('{addr: 16'h0000, data: 16'hABCD});
        exp_q.push_back('{addr: 16'h0001, data: 16'h107F});
        n = 0;
        while (hs_count < 2 && n < 20) begin
            tick;
            n++;
        end
        IR_READY = 1'b0;
        check_output("straight_count", 16'(hs_count), 16'd2);
        check_output("throughput", 16'(hs_cyc[1] - hs_cyc[0]), 16'd2);

        // Backpressure: instruction at 0002 held for five cycles.
        exp_q.push_back('{addr: 16'h0002, data: 16'h538D});
        wait_valid(10);
        for (int i = 0; i < 5; i++) begin
            check_output("bp_ir", IR, 16'h538D);
            check_output("bp_pc_d", PC_D, 16'h0002);
            check_output("bp_mem_req", 16'(MEM_REQ), 16'h0);
            tick;
        end

        // Redirect from HOLD to FFFF, accepting 0002 in the same cycle.
        IR_READY  = 1'b1;
        BR_VALID  = 1'b1;
        BR_TARGET = 16'hFFFF;
        #1;
        check_output("redirect_pc_d", PC_D, 16'hFFFF);
        tick;
        BR_VALID = 1'b0;
        IR_READY = 1'b0;
        check_output("redirect_addr", MEM_ADDR, 16'hFFFF);
        check_output("redirect_req", 16'(MEM_REQ), 16'h1);

        // Wrap: accepting FFFF sends PC and the next fetch to 0000.
        wait_valid(10);
        check_output("wrap_pc_q", pc_reg, 16'hFFFF);
        exp_q.push_back('{addr: 16'hFFFF, data: 16'h7E57});
        IR_READY = 1'b1;
        #1;
        check_output("wrap_pc_d", PC_D, 16'h0000);
        tick;
        IR_READY = 1'b0;
        check_output("wrap_mem_addr", MEM_ADDR, 16'h0000);

        // Branch while a request is outstanding: drain, drop data, refetch 1010.
        wait_valid(10);
        ack_delay = 3;
        exp_q.push_back('{addr: 16'h0000, data: 16'hABCD});
        IR_READY = 1'b1;
        tick;
        IR_READY  = 1'b0;
        BR_VALID  = 1'b1;
        BR_TARGET = 16'h1010;
        tick;
        BR_VALID = 1'b0;
        check_output("drain_mem_req", 16'(MEM_REQ), 16'h1);
        check_output("drain_mem_addr", MEM_ADDR, 16'h0001);
        n = 0;
        while (MEM_ADDR !== 16'h1010 && n < 10) begin
            tick;
            n++;
        end
        check_output("drain_refetch_addr", MEM_ADDR, 16'h1010);
        check_output("drain_ir_valid", 16'(IR_VALID), 16'h0);
        check_output("drain_pc_q", pc_reg, 16'h1010);
        ack_delay = 0;
        exp_q.push_back('{addr: 16'h1010, data: 16'hC0DE});
        wait_valid(10);

        // Timeout: the fetch of 1011 is never acknowledged.
        ack_delay = 255;
        IR_READY  = 1'b1;
        hs_goal   = hs_count + 1;
        n = 0;
        while (hs_count < hs_goal && n < 10) begin
            tick;
            n++;
        end
        IR_READY = 1'b0;
        repeat (14) tick;
        check_output("to_fault_early", 16'(FAULT), 16'h0);
        check_output("to_req_early", 16'(MEM_REQ), 16'h1);
        tick;
        check_output("to_fault", 16'(FAULT), 16'h1);
        check_output("to_mem_req", 16'(MEM_REQ), 16'h0);
        check_output("to_ir_valid", 16'(IR_VALID), 16'h0);

        // FAULT is absorbing and ignores redirects.
        ack_delay = 0;
        BR_VALID  = 1'b1;
        BR_TARGET = 16'h1234;
        #1;
        check_output("fault_pc_d", PC_D, 16'h1011);
        repeat (3) tick;
        BR_VALID = 1'b0;
        check_output("fault_sticky", 16'(FAULT), 16'h1);
        check_output("fault_mem_req", 16'(MEM_REQ), 16'h0);
        check_output("fault_pc_q", pc_reg, 16'h1011);

        // Only reset clears FAULT.
        RST = 1'b1;
        #1;
        check_output("rerst_fault", 16'(FAULT), 16'h0);
        check_output("rerst_mem_req", 16'(MEM_REQ), 16'h0);
        check_output("rerst_pc_d", PC_D, 16'h0000);

        check_output("sb_empty", 16'(exp_q.size()), 16'h0);
        check_output("handshakes", 16'(hs_count), 16'd6);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
